// File: rtl/multicycle_control_unit.sv
// ID-stage control unit. Decodes mode/opcode into execute-stage controls and
// sequences the multi-cycle MUL/MLA operations. A sequence holds IF/ID frozen
// until its final phase, and a flush returns the sequencer to IDLE.
module multicycle_control_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int MLA_CYCLES = 3,
    parameter int PHASE_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [3:0]         opcode,
    input  logic               status,
    input  logic               hazard,
    input  logic               flush,
    output logic [3:0]         exe_cmd,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_en,
    output logic               branch,
    output logic               status_update,
    output logic               freeze,
    output logic               busy,
    output logic [PHASE_W-1:0] phase
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PHASE_W-1:0] MUL_LAST  = PHASE_W'(MUL_CYCLES - 1);
    localparam logic [PHASE_W-1:0] MLA_LAST  = PHASE_W'(MLA_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);

    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_MLA = 4'b0111;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               is_mla_q, is_mla_d;   // latched op kind: 1 = MLA, 0 = MUL

    logic [3:0] cmd;
    logic       rd, wr, wb, br, su, frz;
    logic       last_phase;

    // Sequencer state: synchronous active-low reset, otherwise take next state.
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            is_mla_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            is_mla_q <= is_mla_d;
        end
    end

    // Decode and next-state logic; RUN decodes from the latched op kind only.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        cmd        = 4'b0000;
        rd         = 1'b0;
        wr         = 1'b0;
        wb         = 1'b0;
        br         = 1'b0;
        su         = status;
        frz        = 1'b0;
        state_d    = state_q;
        phase_d    = phase_q;
        is_mla_d   = is_mla_q;
        last_phase = is_mla_q ? (phase_q == MLA_LAST) : (phase_q == MUL_LAST);

        if (state_q == RUN) begin
            wb  = 1'b1;
            cmd = (is_mla_q && last_phase) ? 4'b1110 : 4'b1101;
            frz = !last_phase;
            if (last_phase) begin
                state_d = IDLE;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PHASE_ONE;
            end
        end else begin
            unique case (mode)
                2'b00: begin
                    unique case (opcode)
                        4'b1101: begin cmd = 4'b0001; wb = 1'b1; end  // MOV
                        4'b1111: begin cmd = 4'b1001; wb = 1'b1; end  // MVN
                        4'b0100: begin cmd = 4'b0010; wb = 1'b1; end  // ADD
                        4'b0101: begin cmd = 4'b0011; wb = 1'b1; end  // ADC
                        4'b0010: begin cmd = 4'b0100; wb = 1'b1; end  // SUB
                        4'b0110: begin cmd = 4'b0101; wb = 1'b1; end  // SBC
                        4'b0000: begin cmd = 4'b0110; wb = 1'b1; su = 1'b0; end  // AND
                        4'b1100: begin cmd = 4'b0111; wb = 1'b1; end  // ORR
                        4'b0001: begin cmd = 4'b1000; wb = 1'b1; end  // EOR
                        4'b1010: begin cmd = 4'b0100; su = 1'b1; end  // CMP
                        4'b1000: begin cmd = 4'b0110; su = 1'b1; end  // TST
                        OP_MUL, OP_MLA: begin
                            cmd = 4'b1100;
                            // A hazard stalls the start; phase 0 is retried later.
                            if (!hazard) begin
                                wb  = 1'b1;
                                frz = 1'b1;
                                if (!flush) begin
                                    state_d  = RUN;
                                    phase_d  = PHASE_ONE;
                                    is_mla_d = (opcode == OP_MLA);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                2'b01: begin
                    cmd = 4'b0010;
                    if (status) begin
                        rd = 1'b1;
                        wb = 1'b1;
                    end else begin
                        wr = 1'b1;
                    end
                end
                2'b10:   br = 1'b1;
                default: ;
            endcase
        end

        // Flush kills the current instruction in any state; exe_cmd stays decoded.
        if (flush) begin
            wb      = 1'b0;
            rd      = 1'b0;
            wr      = 1'b0;
            br      = 1'b0;
            frz     = 1'b0;
            state_d = IDLE;
            phase_d = '0;
        end
    end

    // Output stage: everything is held at zero while reset is asserted.
    always_comb begin
        exe_cmd       = rst ? cmd : 4'b0000;
        mem_read      = rst & rd;
        mem_write     = rst & wr;
        wb_en         = rst & wb;
        branch        = rst & br;
        status_update = rst & su;
        freeze        = rst & frz;
        busy          = rst & (state_q == RUN);
        phase         = rst ? phase_q : '0;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (default parameters:
// MUL 2 cycles, MLA 3 cycles). Each step drives one cycle of inputs and
// compares all outputs against hand-computed expectations.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       rst;
        logic [1:0] mode;
        logic [3:0] opcode;
        logic       status;
        logic       hazard;
        logic       flush;
    } in_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic       rd, wr, wb, br, su, frz, busy;
        logic [2:0] ph;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       status, hazard, flush;
    logic [3:0] exe_cmd;
    logic       mem_read, mem_write, wb_en, branch, status_update, freeze, busy;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MUL_CYCLES(2), .MLA_CYCLES(3), .PHASE_W(3)) dut (
        .clk(clk), .rst(rst), .mode(mode), .opcode(opcode), .status(status),
        .hazard(hazard), .flush(flush), .exe_cmd(exe_cmd), .mem_read(mem_read),
        .mem_write(mem_write), .wb_en(wb_en), .branch(branch),
        .status_update(status_update), .freeze(freeze), .busy(busy), .phase(phase)
    );

    function automatic in_t ins(logic r, logic [1:0] m, logic [3:0] op,
                                logic s, logic hz, logic fl);
        ins = '{rst: r, mode: m, opcode: op, status: s, hazard: hz, flush: fl};
    endfunction

    function automatic out_t outs(logic [3:0] c, logic rd, logic wr, logic wb,
                                  logic br, logic su, logic frz, logic bsy,
                                  logic [2:0] ph);
        outs = '{cmd: c, rd: rd, wr: wr, wb: wb, br: br, su: su, frz: frz,
                 busy: bsy, ph: ph};
    endfunction

    // One cycle: drive after the rising edge, compare on the falling edge.
    task automatic step(input string name, input in_t i, input out_t e);
        out_t act;
        @(posedge clk);
        #1;
        rst    = i.rst;
        mode   = i.mode;
        opcode = i.opcode;
        status = i.status;
        hazard = i.hazard;
        flush  = i.flush;
        @(negedge clk);
        act = '{cmd: exe_cmd, rd: mem_read, wr: mem_write, wb: wb_en, br: branch,
                su: status_update, frz: freeze, busy: busy, ph: phase};
        check(name, act, e);
    endtask

    task automatic check(input string name, input out_t act, input out_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got cmd=%b rd=%b wr=%b wb=%b br=%b su=%b frz=%b busy=%b ph=%0d ; want cmd=%b rd=%b wr=%b wb=%b br=%b su=%b frz=%b busy=%b ph=%0d",
                     name, act.cmd, act.rd, act.wr, act.wb, act.br, act.su, act.frz,
                     act.busy, act.ph, e.cmd, e.rd, e.wr, e.wb, e.br, e.su, e.frz,
                     e.busy, e.ph);
        end
    endtask

    vec_t tbl[18];
    out_t zero;

    initial begin
        rst = 1'b0; mode = 2'b00; opcode = 4'b0000;
        status = 1'b0; hazard = 1'b0; flush = 1'b0;
        zero = outs(4'b0000, 0, 0, 0, 0, 0, 0, 0, 3'd0);

        // Single-cycle decode sweep; every row is an IDLE cycle.
        tbl[0]  = '{ins(1, 2'b00, 4'b1101, 0, 0, 0), outs(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0)}; // MOV
        tbl[1]  = '{ins(1, 2'b00, 4'b1111, 1, 0, 0), outs(4'b1001, 0, 0, 1, 0, 1, 0, 0, 0)}; // MVN S
        tbl[2]  = '{ins(1, 2'b00, 4'b0100, 0, 0, 0), outs(4'b0010, 0, 0, 1, 0, 0, 0, 0, 0)}; // ADD
        tbl[3]  = '{ins(1, 2'b00, 4'b0101, 0, 0, 0), outs(4'b0011, 0, 0, 1, 0, 0, 0, 0, 0)}; // ADC
        tbl[4]  = '{ins(1, 2'b00, 4'b0010, 1, 0, 0), outs(4'b0100, 0, 0, 1, 0, 1, 0, 0, 0)}; // SUB S
        tbl[5]  = '{ins(1, 2'b00, 4'b0110, 0, 0, 0), outs(4'b0101, 0, 0, 1, 0, 0, 0, 0, 0)}; // SBC
        tbl[6]  = '{ins(1, 2'b00, 4'b0000, 1, 0, 0), outs(4'b0110, 0, 0, 1, 0, 0, 0, 0, 0)}; // AND, S ignored
        tbl[7]  = '{ins(1, 2'b00, 4'b1100, 0, 0, 0), outs(4'b0111, 0, 0, 1, 0, 0, 0, 0, 0)}; // ORR
        tbl[8]  = '{ins(1, 2'b00, 4'b0001, 0, 0, 0), outs(4'b1000, 0, 0, 1, 0, 0, 0, 0, 0)}; // EOR
        tbl[9]  = '{ins(1, 2'b00, 4'b1010, 0, 0, 0), outs(4'b0100, 0, 0, 0, 0, 1, 0, 0, 0)}; // CMP
        tbl[10] = '{ins(1, 2'b00, 4'b1000, 0, 0, 0), outs(4'b0110, 0, 0, 0, 0, 1, 0, 0, 0)}; // TST
        tbl[11] = '{ins(1, 2'b00, 4'b1011, 1, 0, 0), outs(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0)}; // undefined
        tbl[12] = '{ins(1, 2'b01, 4'b0000, 1, 0, 0), outs(4'b0010, 1, 0, 1, 0, 1, 0, 0, 0)}; // LDR
        tbl[13] = '{ins(1, 2'b01, 4'b0000, 0, 0, 0), outs(4'b0010, 0, 1, 0, 0, 0, 0, 0, 0)}; // STR
        tbl[14] = '{ins(1, 2'b10, 4'b0101, 1, 0, 0), outs(4'b0000, 0, 0, 0, 1, 1, 0, 0, 0)}; // B
        tbl[15] = '{ins(1, 2'b11, 4'b0100, 0, 0, 0), zero};                                 // mode 11
        tbl[16] = '{ins(1, 2'b00, 4'b0100, 0, 0, 1), outs(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0)}; // ADD flushed
        tbl[17] = '{ins(1, 2'b01, 4'b0000, 1, 0, 1), outs(4'b0010, 0, 0, 0, 0, 1, 0, 0, 0)}; // LDR flushed

        // Reset with a MUL on the inputs: everything stays 0.
        step("reset0", ins(0, 2'b00, 4'b0011, 1, 0, 0), zero);
        step("reset1", ins(0, 2'b00, 4'b0011, 1, 0, 0), zero);

        // MUL: phase 0 then phase 1, then back to IDLE.
        step("mul_p0", ins(1, 2'b00, 4'b0011, 0, 0, 0), outs(4'b1100, 0, 0, 1, 0, 0, 1, 0, 0));
        step("mul_p1", ins(1, 2'b00, 4'b0011, 0, 0, 0), outs(4'b1101, 0, 0, 1, 0, 0, 0, 1, 1));
        step("mul_idle", ins(1, 2'b11, 4'b0000, 0, 0, 0), zero);

        // MLA: 1100, 1101, 1110 with freeze 1, 1, 0.
        step("mla_p0", ins(1, 2'b00, 4'b0111, 1, 0, 0), outs(4'b1100, 0, 0, 1, 0, 1, 1, 0, 0));
        step("mla_p1", ins(1, 2'b11, 4'b0000, 1, 0, 0), outs(4'b1101, 0, 0, 1, 0, 1, 1, 1, 1));
        step("mla_p2", ins(1, 2'b11, 4'b0000, 1, 0, 0), outs(4'b1110, 0, 0, 1, 0, 1, 0, 1, 2));

        // Back-to-back MUL right after MLA; opcode changed mid-run is ignored.
        step("b2b_p0", ins(1, 2'b00, 4'b0011, 0, 0, 0), outs(4'b1100, 0, 0, 1, 0, 0, 1, 0, 0));
        step("ignore_p1", ins(1, 2'b00, 4'b1101, 0, 0, 0), outs(4'b1101, 0, 0, 1, 0, 0, 0, 1, 1));
        step("ignore_done", ins(1, 2'b00, 4'b1101, 0, 0, 0), outs(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0));

        // Hazard stalls the start for two cycles; hazard in RUN is ignored.
        step("haz0", ins(1, 2'b00, 4'b0011, 0, 1, 0), outs(4'b1100, 0, 0, 0, 0, 0, 0, 0, 0));
        step("haz1", ins(1, 2'b00, 4'b0011, 0, 1, 0), outs(4'b1100, 0, 0, 0, 0, 0, 0, 0, 0));
        step("haz_p0", ins(1, 2'b00, 4'b0011, 0, 0, 0), outs(4'b1100, 0, 0, 1, 0, 0, 1, 0, 0));
        step("haz_p1", ins(1, 2'b00, 4'b0011, 0, 1, 0), outs(4'b1101, 0, 0, 1, 0, 0, 0, 1, 1));

        // Flush at MLA phase 1 aborts; next cycle decodes ADD from IDLE.
        step("fl_p0", ins(1, 2'b00, 4'b0111, 0, 0, 0), outs(4'b1100, 0, 0, 1, 0, 0, 1, 0, 0));
        step("fl_p1", ins(1, 2'b00, 4'b0111, 0, 0, 1), outs(4'b1101, 0, 0, 0, 0, 0, 0, 1, 1));
        step("fl_add", ins(1, 2'b00, 4'b0100, 0, 0, 0), outs(4'b0010, 0, 0, 1, 0, 0, 0, 0, 0));

        // Flush on a MUL start in IDLE: nothing starts.
        step("fl_idle", ins(1, 2'b00, 4'b0011, 0, 0, 1), outs(4'b1100, 0, 0, 0, 0, 0, 0, 0, 0));
        step("fl_idle_after", ins(1, 2'b11, 4'b0000, 0, 0, 0), zero);

        // Reset in the middle of an MLA sequence.
        step("rst_p0", ins(1, 2'b00, 4'b0111, 0, 0, 0), outs(4'b1100, 0, 0, 1, 0, 0, 1, 0, 0));
        step("rst_mid", ins(0, 2'b00, 4'b0111, 1, 0, 0), zero);
        step("rst_after", ins(1, 2'b11, 4'b0000, 0, 0, 0), zero);

        for (int k = 0; k < 18; k++)
            step($sformatf("decode%0d", k), tbl[k].i, tbl[k].o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
